// File: rtl/inst_fetch_pkg.sv
// -----------------------------------------------------------------------------
// inst_fetch_pkg
// Shared front-end definitions: RV32 major opcodes (also used by the decoder)
// and the J-type immediate extraction helper.
// No ports (package).
// -----------------------------------------------------------------------------
package inst_fetch_pkg;

    // RV32I major opcodes, inst[6:0]
    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_e;

    localparam int XLEN = 32;

    // Sign-extended J-type immediate {inst[31],inst[19:12],inst[20],inst[30:21],0}
    function automatic logic signed [XLEN-1:0] jal_imm(input logic [XLEN-1:0] inst);
        jal_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/inst_fetch_next_pc.sv
// -----------------------------------------------------------------------------
// fetch_next_pc
// Combinational next-PC predictor. JAL targets are followed; every other
// instruction (branches included, predicted not-taken) advances by 4.
// The addition wraps modulo 2^32.
// Ports:
//   pc      in  [31:0]  PC of the fetched instruction
//   inst    in  [31:0]  fetched instruction word
//   next_pc out [31:0]  predicted address of the following instruction
// -----------------------------------------------------------------------------
module fetch_next_pc
    import inst_fetch_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] next_pc
);

    logic signed [XLEN-1:0] offset;
    logic                   unused_rd;

    // rd and funct bits play no part in the prediction
    assign unused_rd = ^inst[11:7];

    always_comb begin
        offset = 32'sd4;
        if (inst[6:0] == OPC_JAL) begin
            offset = jal_imm(inst);
        end
        next_pc = pc + $unsigned(offset);
    end

endmodule

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// Single-outstanding-request instruction fetch unit. Fetches one word at a
// time from the memory controller, offers it to the decoder with a
// valid/ready handshake, and follows JAL targets. A clear from the ROB
// redirects the PC and drops whatever is in flight or held.
// Ports:
//   clk_in      in        clock, rising edge
//   rst_in      in        asynchronous active-high reset
//   rdy_in      in        global enable; low freezes all state
//   clear       in        flush/redirect
//   clear_pc    in  [31:0] redirect target
//   dec_ready   in        decoder accepts this cycle
//   to_dec      out       instruction valid toward decoder
//   to_dec_pc   out [31:0] PC of offered instruction
//   to_dec_inst out [31:0] offered instruction
//   mem_req     out       fetch request
//   mem_addr    out [31:0] fetch address
//   mem_done    in        fetched word valid (one-cycle pulse)
//   mem_data    in  [31:0] fetched word
// -----------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic [31:0] clear_pc,
    input  logic        dec_ready,
    output logic        to_dec,
    output logic [31:0] to_dec_pc,
    output logic [31:0] to_dec_inst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_data
);

    // IDLE : about to issue a fetch at pc
    // WAIT : request outstanding, waiting for mem_done
    // HOLD : instruction offered to decoder, waiting for dec_ready
    // DRAIN: request abandoned by a clear, swallowing its mem_done
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    state_e      state_q,       state_d;
    logic [31:0] pc_q,          pc_d;
    logic        to_dec_q,      to_dec_d;
    logic [31:0] to_dec_pc_q,   to_dec_pc_d;
    logic [31:0] to_dec_inst_q, to_dec_inst_d;
    logic        mem_req_q,     mem_req_d;
    logic [31:0] mem_addr_q,    mem_addr_d;
    logic [31:0] next_pc;

    fetch_next_pc u_next_pc (
        .pc      (pc_q),
        .inst    (mem_data),
        .next_pc (next_pc)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            to_dec_q      <= 1'b0;
            to_dec_pc_q   <= 32'h0;
            to_dec_inst_q <= 32'h0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'h0;
        end else if (rdy_in) begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            to_dec_q      <= to_dec_d;
            to_dec_pc_q   <= to_dec_pc_d;
            to_dec_inst_q <= to_dec_inst_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        to_dec_d      = to_dec_q;
        to_dec_pc_d   = to_dec_pc_q;
        to_dec_inst_d = to_dec_inst_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;

        if (clear) begin
            // Redirect wins over every other event; held data is dropped.
            pc_d     = clear_pc;
            to_dec_d = 1'b0;
            case (state_q)
                IDLE: state_d = IDLE;
                WAIT: begin
                    mem_req_d = 1'b0;
                    // A response arriving with the clear closes the request.
                    state_d   = mem_done ? IDLE : DRAIN;
                end
                HOLD:  state_d = IDLE;
                DRAIN: state_d = mem_done ? IDLE : DRAIN;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                    state_d    = WAIT;
                end
                WAIT: begin
                    if (mem_done) begin
                        mem_req_d     = 1'b0;
                        to_dec_d      = 1'b1;
                        to_dec_inst_d = mem_data;
                        to_dec_pc_d   = pc_q;
                        pc_d          = next_pc;
                        state_d       = HOLD;
                    end
                end
                HOLD: begin
                    // Transfer and refetch on the same edge: no idle bubble.
                    if (dec_ready) begin
                        to_dec_d   = 1'b0;
                        mem_req_d  = 1'b1;
                        mem_addr_d = pc_q;
                        state_d    = WAIT;
                    end
                end
                DRAIN: begin
                    mem_req_d = 1'b0;
                    if (mem_done) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign to_dec      = to_dec_q;
    assign to_dec_pc   = to_dec_pc_q;
    assign to_dec_inst = to_dec_inst_q;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clear;
    logic [31:0] clear_pc;
    logic        dec_ready;
    logic        to_dec;
    logic [31:0] to_dec_pc;
    logic [31:0] to_dec_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[10];

    inst_fetch #(.RESET_PC(32'h0)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .clear       (clear),
        .clear_pc    (clear_pc),
        .dec_ready   (dec_ready),
        .to_dec      (to_dec),
        .to_dec_pc   (to_dec_pc),
        .to_dec_inst (to_dec_inst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_done    (mem_done),
        .mem_data    (mem_data)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic quiet();
        clear     = 1'b0;
        clear_pc  = 32'h0;
        dec_ready = 1'b0;
        mem_done  = 1'b0;
        mem_data  = 32'h0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0008, 32'h0100_006F, 32'h0000_0018}; // JAL +16
        vecs[1] = '{32'h0000_0018, 32'h0000_0463, 32'h0000_001C}; // BEQ, not taken
        vecs[2] = '{32'hFFFF_FFFC, 32'h0000_0013, 32'h0000_0000}; // NOP, wrap
        vecs[3] = '{32'h0000_0100, 32'hFFDF_F06F, 32'h0000_00FC}; // JAL -4
        vecs[4] = '{32'hFFFF_FFF0, 32'h0100_006F, 32'h0000_0000}; // JAL wrap
        vecs[5] = '{32'h0000_1000, 32'h0010_00EF, 32'h0000_1800}; // JAL +2048 (imm[11])
        vecs[6] = '{32'h0000_0200, 32'h0000_80E7, 32'h0000_0204}; // JALR -> +4
        vecs[7] = '{32'h0000_0040, 32'h0100_006B, 32'h0000_0044}; // near-JAL opcode
        vecs[8] = '{32'h0000_2000, 32'h8000_006F, 32'hFFF0_2000}; // JAL -2^20
        vecs[9] = '{32'h0000_0300, 32'h0000_106F, 32'h0000_1300}; // JAL +4096 (imm[12])

        quiet();
        rst_in = 1'b1;
        rdy_in = 1'b1;

        // Reset values, visible before any clock edge
        #2;
        chk("rst_to_dec",      {31'h0, to_dec},  32'h0);
        chk("rst_to_dec_pc",   to_dec_pc,        32'h0);
        chk("rst_to_dec_inst", to_dec_inst,      32'h0);
        chk("rst_mem_req",     {31'h0, mem_req}, 32'h0);
        chk("rst_mem_addr",    mem_addr,         32'h0);
        tick();
        chk("rst_hold_req", {31'h0, mem_req}, 32'h0);

        // Release with rdy_in low: nothing happens until rdy_in rises
        rst_in = 1'b0;
        rdy_in = 1'b0;
        tick();
        chk("rdy0_no_req", {31'h0, mem_req}, 32'h0);
        rdy_in = 1'b1;
        tick();
        chk("first_req",  {31'h0, mem_req}, 32'h1);
        chk("first_addr", mem_addr,         32'h0);
        tick();
        chk("wait_req1", {31'h0, mem_req}, 32'h1);
        tick();
        chk("wait_req2", {31'h0, mem_req}, 32'h1);
        mem_done = 1'b1; mem_data = 32'h0000_0013;
        tick();
        chk("hold_to_dec", {31'h0, to_dec},  32'h1);
        chk("hold_pc",     to_dec_pc,        32'h0);
        chk("hold_inst",   to_dec_inst,      32'h0000_0013);
        chk("hold_noreq",  {31'h0, mem_req}, 32'h0);
        quiet(); dec_ready = 1'b1;
        tick();
        chk("xfer_to_dec", {31'h0, to_dec},  32'h0);
        chk("xfer_req",    {31'h0, mem_req}, 32'h1);
        chk("xfer_addr",   mem_addr,         32'h4);

        // Decoder stall in HOLD
        quiet(); mem_done = 1'b1; mem_data = 32'h0010_0093;
        tick();
        quiet();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_to_dec", {31'h0, to_dec},  32'h1);
            chk("stall_pc",     to_dec_pc,        32'h4);
            chk("stall_inst",   to_dec_inst,      32'h0010_0093);
            chk("stall_noreq",  {31'h0, mem_req}, 32'h0);
        end
        dec_ready = 1'b1;
        tick();
        chk("stall_xfer",      {31'h0, to_dec},  32'h0);
        chk("stall_xfer_addr", mem_addr,         32'h8);
        chk("stall_xfer_req",  {31'h0, mem_req}, 32'h1);

        // Clear in WAIT -> DRAIN, second clear while draining, late mem_done
        quiet();
        tick();
        clear = 1'b1; clear_pc = 32'h180;
        tick();
        chk("drain_noreq",  {31'h0, mem_req}, 32'h0);
        chk("drain_to_dec", {31'h0, to_dec},  32'h0);
        clear = 1'b1; clear_pc = 32'h100;
        tick();
        chk("drain2_noreq", {31'h0, mem_req}, 32'h0);
        quiet();
        tick();
        chk("drain3_noreq", {31'h0, mem_req}, 32'h0);
        mem_done = 1'b1; mem_data = 32'hDEAD_BEEF;
        tick();
        chk("drain_done_to_dec", {31'h0, to_dec},  32'h0);
        chk("drain_done_noreq",  {31'h0, mem_req}, 32'h0);
        quiet();
        tick();
        chk("redirect_to_dec", {31'h0, to_dec},  32'h0);
        chk("redirect_req",    {31'h0, mem_req}, 32'h1);
        chk("redirect_addr",   mem_addr,         32'h100);

        // Clear in HOLD with dec_ready=1: no transfer
        mem_done = 1'b1; mem_data = 32'h0000_0013;
        tick();
        chk("d_hold_to_dec", {31'h0, to_dec}, 32'h1);
        chk("d_hold_pc",     to_dec_pc,       32'h100);
        quiet(); clear = 1'b1; clear_pc = 32'h40; dec_ready = 1'b1;
        tick();
        chk("hold_clr_to_dec", {31'h0, to_dec},  32'h0);
        chk("hold_clr_noreq",  {31'h0, mem_req}, 32'h0);
        quiet();
        tick();
        chk("hold_clr_req",  {31'h0, mem_req}, 32'h1);
        chk("hold_clr_addr", mem_addr,         32'h40);

        // rdy_in low freezes everything, even with all inputs active
        rdy_in = 1'b0; mem_done = 1'b1; mem_data = 32'h0100_006F;
        clear = 1'b1; clear_pc = 32'h999; dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("frz_req",    {31'h0, mem_req}, 32'h1);
            chk("frz_addr",   mem_addr,         32'h40);
            chk("frz_to_dec", {31'h0, to_dec},  32'h0);
        end
        rdy_in = 1'b1; clear = 1'b0; dec_ready = 1'b0;
        tick();
        chk("frz_rel_to_dec", {31'h0, to_dec}, 32'h1);
        chk("frz_rel_pc",     to_dec_pc,       32'h40);
        chk("frz_rel_inst",   to_dec_inst,     32'h0100_006F);
        quiet(); rdy_in = 1'b0; dec_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("frz_hold_to_dec", {31'h0, to_dec},  32'h1);
            chk("frz_hold_noreq",  {31'h0, mem_req}, 32'h0);
        end
        rdy_in = 1'b1;
        tick();
        chk("frz_jal_req",  {31'h0, mem_req}, 32'h1);
        chk("frz_jal_addr", mem_addr,         32'h50);

        // Table: redirect via clear+mem_done, fetch, transfer, check next address
        for (int i = 0; i < 10; i++) begin
            quiet(); clear = 1'b1; mem_done = 1'b1;
            clear_pc = vecs[i].pc; mem_data = 32'hFFFF_FFFF;
            tick();
            chk("v_clr_to_dec", {31'h0, to_dec},  32'h0);
            chk("v_clr_noreq",  {31'h0, mem_req}, 32'h0);
            quiet();
            tick();
            chk("v_req",  {31'h0, mem_req}, 32'h1);
            chk("v_addr", mem_addr,         vecs[i].pc);
            mem_done = 1'b1; mem_data = vecs[i].inst;
            tick();
            chk("v_to_dec", {31'h0, to_dec}, 32'h1);
            chk("v_pc",     to_dec_pc,       vecs[i].pc);
            chk("v_inst",   to_dec_inst,     vecs[i].inst);
            quiet(); dec_ready = 1'b1;
            tick();
            chk("v_next_req",  {31'h0, mem_req}, 32'h1);
            chk("v_next_addr", mem_addr,         vecs[i].exp_next);
            chk("v_next_vld",  {31'h0, to_dec},  32'h0);
        end

        // Asynchronous reset mid-operation, stale mem_done afterwards
        quiet();
        tick();
        #2 rst_in = 1'b1;
        #1;
        chk("arst_req",     {31'h0, mem_req}, 32'h0);
        chk("arst_addr",    mem_addr,         32'h0);
        chk("arst_to_pc",   to_dec_pc,        32'h0);
        chk("arst_to_inst", to_dec_inst,      32'h0);
        tick();
        rst_in = 1'b0; mem_done = 1'b1; mem_data = 32'h0100_006F;
        tick();
        chk("arst_stale_to_dec", {31'h0, to_dec},  32'h0);
        chk("arst_stale_req",    {31'h0, mem_req}, 32'h1);
        chk("arst_stale_addr",   mem_addr,         32'h0);
        quiet();
        tick();
        chk("arst_wait_req", {31'h0, mem_req}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0, giving the PC value loaded on reset.
REQ-002 The block SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_in, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port rdy_in, input, 1 bit: global enable; when low, all state including outputs is frozen.
REQ-005 The block SHALL have port clear, input, 1 bit: pipeline flush/redirect from the ROB.
REQ-006 The block SHALL have port clear_pc, input, 32 bits: the redirect target, valid when clear=1.
REQ-007 The block SHALL have port dec_ready, input, 1 bit: the decoder can accept an instruction this cycle.
REQ-008 The block SHALL have port to_dec, output, 1 bit: instruction valid toward the decoder.
REQ-009 The block SHALL have port to_dec_pc, output, 32 bits: the PC of the offered instruction.
REQ-010 The block SHALL have port to_dec_inst, output, 32 bits: the offered instruction word.
REQ-011 The block SHALL have port mem_req, output, 1 bit: word-fetch request to the memory controller.
REQ-012 The block SHALL have port mem_addr, output, 32 bits: the fetch address, stable while mem_req=1.
REQ-013 The block SHALL have port mem_done, input, 1 bit: one-cycle pulse, fetched word valid.
REQ-014 The block SHALL have port mem_data, input, 32 bits: the fetched word, valid when mem_done=1.

Function
REQ-015 The FSM SHALL have four states: IDLE, WAIT, HOLD, DRAIN; every output SHALL be registered.
REQ-016 In IDLE, the block SHALL set mem_req<=1 and mem_addr<=pc, and go to WAIT.
REQ-017 In WAIT, mem_req SHALL stay 1 until mem_done=1.
REQ-018 On mem_done in WAIT, the block SHALL set mem_req<=0, to_dec<=1, to_dec_inst<=mem_data, to_dec_pc<=pc and pc<=next_pc, and go to HOLD.
REQ-019 next_pc SHALL be pc+sext(J-imm {inst[31],inst[19:12],inst[20],inst[30:21],0}) when inst[6:0]=7'b1101111 (JAL), and pc+4 for every other instruction including branches (predicted not-taken); the sum SHALL wrap modulo 2^32.
REQ-020 A transfer SHALL occur on a rising edge where to_dec=1 and dec_ready=1; to_dec, to_dec_pc and to_dec_inst SHALL stay stable in HOLD until that transfer.
REQ-021 On a transfer, the block SHALL set to_dec<=0, mem_req<=1 and mem_addr<=pc in the same edge, and go to WAIT; the refetch therefore starts with no idle bubble.
REQ-022 clear=1 (with rdy_in=1) SHALL take priority over all other events: to_dec<=0 and pc<=clear_pc.
REQ-023 If clear=1 in WAIT and mem_done=0, the block SHALL set mem_req<=0 and go to DRAIN.
REQ-024 If clear=1 in WAIT and mem_done=1 in the same cycle, the data SHALL be discarded and the block SHALL go to IDLE.
REQ-025 If clear=1 in HOLD, the block SHALL go to IDLE whatever the value of dec_ready; the held instruction is dropped.
REQ-026 If clear=1 in IDLE, the block SHALL stay in IDLE with the new pc.
REQ-027 In DRAIN, mem_req SHALL be 0; on mem_done the data SHALL be ignored and the block SHALL go to IDLE.
REQ-028 If clear=1 in DRAIN, pc SHALL be updated and the block SHALL remain in DRAIN until mem_done.
REQ-029 The block SHALL never have more than one memory request outstanding.
REQ-030 The fetch latency SHALL be IDLE->mem_req in 1 cycle, and mem_done->to_dec in 1 cycle.

Reset
REQ-031 While rst_in=1, asynchronously: pc=RESET_PC, state=IDLE, to_dec=0, to_dec_pc=0, to_dec_inst=0, mem_req=0, mem_addr=0.
REQ-032 After rst_in falls, the first mem_req SHALL assert on the first rising edge with rdy_in=1.
REQ-033 Reset mid-operation SHALL abandon any in-flight request; a later mem_done SHALL be ignored unless the block is in WAIT.

Structure
REQ-034 Opcode constants (JAL 7'b1101111, BRANCH, and the others) SHALL come from the shared package also used by the decoder.
REQ-035 The FSM state encoding SHALL be local to this block.
REQ-036 One combinational sub-module, fetch_next_pc (inputs pc and inst, output next_pc), SHALL implement REQ-019.

Verification
REQ-037 Reset with RESET_PC=0, memory returning 32'h00000013 after 3 cycles -> mem_addr=0; to_dec=1 with to_dec_pc=0; with dec_ready=1 the next mem_addr=4 on the same edge.
REQ-038 At pc=8, fetching JAL x0,+16 (32'h0100006F) -> the next mem_addr=24; a BEQ at pc=24 -> the next mem_addr=28.
REQ-039 dec_ready held 0 for 5 cycles in HOLD -> to_dec, to_dec_pc and to_dec_inst unchanged and no mem_req; the transfer occurs on the first dec_ready=1 edge.
REQ-040 clear with clear_pc=32'h100 two cycles into WAIT, mem_done 3 cycles later -> that data is never presented; the next mem_addr=32'h100.
REQ-041 clear and mem_done on the same edge -> no to_dec; the fetch at clear_pc starts one cycle later. A clear in HOLD with dec_ready=1 -> to_dec falls and no transfer occurs.
REQ-042 rdy_in=0 for 4 cycles mid-WAIT, and pc=32'hFFFFFFFC -> all state is frozen; the next sequential fetch address wraps to 0.
